// File: rtl/fft_pkg.sv
// Shared FFT definitions: default sample/address widths, the readout state
// type and a bit-reverse helper used by the address generator, the loader and
// the readout unit.
package fft_pkg;

    localparam int unsigned FFT_DATA_W = 16;
    localparam int unsigned FFT_ADDR_W = 5;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_RUN   = 2'd1,
        RD_FLUSH = 2'd2
    } rd_state_e;

    // Reverses the low 'width' bits of value; bits above 'width' return 0.
    function automatic logic [31:0] bitrev(input logic [31:0] value,
                                           input int unsigned width);
        logic [31:0] result;
        result = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < width) begin
                result[5'(i)] = value[5'(width - 1 - i)];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/skid_fifo_2.sv
// Two-entry FIFO with a fall-through path when empty.
// Ports:
//   clk, clr            clock, synchronous active-high clear
//   in_valid, in_data   push side (no back-pressure; caller limits pushes)
//   out_valid/out_ready/out_data  pop side, valid/ready handshake
//   count               number of stored entries (0..2)
module skid_fifo_2 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem0_q, mem0_d;
    logic [WIDTH-1:0] mem1_q, mem1_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             empty;
    logic             bypass;
    logic             drain;
    logic             store;

    always_comb begin
        mem0_d   = mem0_q;
        mem1_d   = mem1_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        empty     = (count_q == 2'd0);
        out_valid = !empty || in_valid;
        out_data  = '0;
        if (!empty) begin
            out_data = rd_ptr_q ? mem1_q : mem0_q;
        end else if (in_valid) begin
            out_data = in_data;
        end

        // An arriving word taken in the same cycle never occupies a slot,
        // which keeps occupancy at 0 during back-to-back streaming.
        bypass = empty && in_valid && out_ready;
        drain  = !empty && out_ready;
        // When full, a push is only accepted alongside a pop.
        store  = in_valid && !bypass && ((count_q != 2'd2) || drain);

        if (store) begin
            if (wr_ptr_q) begin
                mem1_d = in_data;
            end else begin
                mem0_d = in_data;
            end
            wr_ptr_d = ~wr_ptr_q;
        end
        if (drain) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, store} - {1'b0, drain};
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            mem0_q   <= '0;
            mem1_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            mem0_q   <= mem0_d;
            mem1_q   <= mem1_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fft_readout_unit.sv
// FFT result readout: on a rising edge of fft_done, reads all N = 2^ADDR_W
// bins from the result bank (bit-reversed or natural addressing) and streams
// them out in natural bin order over a valid/ready interface.
// Ports:
//   clk, clr                         clock, synchronous active-high reset
//   fft_done, bank_select            start level (edge-detected) and result bank
//   rd_en, rd_address, rd_bank       memory read request (data 1 cycle later)
//   rd_data                          {re, im} returned by the memory
//   out_valid/out_ready/out_data     output stream, out_index = bin number
//   out_index, out_last              bin number, high on bin N-1
//   busy, readout_done               in progress, one-cycle completion pulse
module fft_readout_unit
    import fft_pkg::*;
#(
    parameter int unsigned DATA_W = FFT_DATA_W,
    parameter int unsigned ADDR_W = FFT_ADDR_W,
    parameter bit          BITREV = 1'b1
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                fft_done,
    input  logic                bank_select,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_address,
    output logic                rd_bank,
    input  logic [2*DATA_W-1:0] rd_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0]   out_index,
    output logic                out_last,
    output logic                busy,
    output logic                readout_done
);

    rd_state_e         state_q, state_d;
    logic              fft_done_q, fft_done_d;
    logic              arm_q, arm_d;
    logic              bank_q, bank_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              readout_done_q, readout_done_d;

    logic [1:0]        fifo_count;
    logic              fifo_in_valid;
    logic              beat;
    logic              issue_ok;

    // A read returning during reset is dropped rather than pushed.
    assign fifo_in_valid = inflight_q && !clr;

    skid_fifo_2 #(
        .WIDTH(2 * DATA_W)
    ) u_fifo (
        .clk      (clk),
        .clr      (clr),
        .in_valid (fifo_in_valid),
        .in_data  (rd_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (fifo_count)
    );

    always_comb begin
        state_d        = state_q;
        fft_done_d     = fft_done;
        arm_d          = 1'b1;
        bank_d         = bank_q;
        k_d            = k_q;
        idx_d          = idx_q;
        rd_en          = 1'b0;
        readout_done_d = 1'b0;

        beat     = out_valid && out_ready;
        issue_ok = ({1'b0, fifo_count} + {2'b00, inflight_q}) < 3'd2;

        if (beat) begin
            idx_d = idx_q + ADDR_W'(1);
        end

        unique case (state_q)
            RD_IDLE: begin
                // arm_q masks the first cycle after reset so a level already
                // high at release is not mistaken for an edge.
                if (arm_q && fft_done && !fft_done_q) begin
                    state_d = RD_RUN;
                    bank_d  = bank_select;
                    k_d     = '0;
                    idx_d   = '0;
                end
            end
            RD_RUN: begin
                if (issue_ok && !clr) begin
                    rd_en = 1'b1;
                    k_d   = k_q + ADDR_W'(1);
                    if (k_q == '1) begin
                        state_d = RD_FLUSH;
                    end
                end
            end
            RD_FLUSH: begin
                if (beat && out_last) begin
                    state_d        = RD_IDLE;
                    readout_done_d = 1'b1;
                end
            end
            default: state_d = RD_IDLE;
        endcase

        inflight_d = rd_en;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q        <= RD_IDLE;
            fft_done_q     <= 1'b0;
            arm_q          <= 1'b0;
            bank_q         <= 1'b0;
            k_q            <= '0;
            inflight_q     <= 1'b0;
            idx_q          <= '0;
            readout_done_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            fft_done_q     <= fft_done_d;
            arm_q          <= arm_d;
            bank_q         <= bank_d;
            k_q            <= k_d;
            inflight_q     <= inflight_d;
            idx_q          <= idx_d;
            readout_done_q <= readout_done_d;
        end
    end

    assign rd_address   = BITREV ? ADDR_W'(bitrev(32'(k_q), ADDR_W)) : k_q;
    assign rd_bank      = bank_q;
    assign out_index    = idx_q;
    assign out_last     = out_valid && (idx_q == '1);
    assign busy         = (state_q != RD_IDLE);
    assign readout_done = readout_done_q;

endmodule

// File: tb/tb_fft_readout_unit.sv
module tb_fft_readout_unit;

    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int N     = 32;
    localparam int LIMIT = 300;

    logic clk = 1'b0;
    logic clr;
    logic fft_done;
    logic bank_select;
    logic out_ready;

    // Index 0: bit-reversed instance, index 1: natural-order instance.
    logic [1:0]      rd_en;
    logic [AW-1:0]   rd_address [2];
    logic [1:0]      rd_bank;
    logic [2*DW-1:0] rd_data    [2];
    logic [1:0]      out_valid;
    logic [2*DW-1:0] out_data   [2];
    logic [AW-1:0]   out_index  [2];
    logic [1:0]      out_last;
    logic [1:0]      busy;
    logic [1:0]      readout_done;

    logic [31:0] mem [2][N];

    int checks = 0;
    int errors = 0;

    fft_readout_unit #(.DATA_W(DW), .ADDR_W(AW), .BITREV(1'b1)) u_dut_rev (
        .clk(clk), .clr(clr), .fft_done(fft_done), .bank_select(bank_select),
        .rd_en(rd_en[0]), .rd_address(rd_address[0]), .rd_bank(rd_bank[0]),
        .rd_data(rd_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_data(out_data[0]), .out_index(out_index[0]), .out_last(out_last[0]),
        .busy(busy[0]), .readout_done(readout_done[0])
    );

    fft_readout_unit #(.DATA_W(DW), .ADDR_W(AW), .BITREV(1'b0)) u_dut_nat (
        .clk(clk), .clr(clr), .fft_done(fft_done), .bank_select(bank_select),
        .rd_en(rd_en[1]), .rd_address(rd_address[1]), .rd_bank(rd_bank[1]),
        .rd_data(rd_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_data(out_data[1]), .out_index(out_index[1]), .out_last(out_last[1]),
        .busy(busy[1]), .readout_done(readout_done[1])
    );

    initial forever #5 clk = ~clk;

    // Synchronous-read memory: data valid the cycle after rd_en, garbage otherwise.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rd_en[d]) rd_data[d] <= mem[rd_bank[d]][rd_address[d]];
            else          rd_data[d] <= $urandom();
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rev5(input int v);
        int r;
        r = 0;
        for (int b = 0; b < AW; b++) if (((v >> b) & 1) != 0) r = r | (1 << (AW - 1 - b));
        return r;
    endfunction

    // Memory address holding bin i for instance d.
    function automatic int exp_addr(input int d, input int i);
        return (d == 0) ? rev5(i) : i;
    endfunction

    // mode 0: ready always; 1: pattern 1,0,0,1; 2: random; 3: low 5 cycles after start
    function automatic logic ready_at(input int mode, input int c);
        case (mode)
            1:       return ((c % 4) == 0) || ((c % 4) == 3);
            2:       return 1'($urandom_range(0, 1));
            3:       return !((c >= 1) && (c <= 5));
            default: return 1'b1;
        endcase
    endfunction

    task automatic check_idle(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_busy"}, busy[d], 0);
            chk({tag, "_rd_en"}, rd_en[d], 0);
            chk({tag, "_out_valid"}, out_valid[d], 0);
        end
    endtask

    task automatic run_readout(input int mode, input int clr_beat, input int redge_beat,
                               input logic bank, input bit rnd_mem);
        int cyc, abort_cyc, first_beat, last_beat;
        int issued [2];
        int acc    [2];
        int dones  [2];
        bit last_prev [2];
        bit finished, redge;
        logic [31:0] expd [2][N];

        for (int b = 0; b < 2; b++)
            for (int a = 0; a < N; a++)
                mem[b][a] = rnd_mem ? $urandom() : ((32'(b) << 16) | 32'(a));
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < N; i++) expd[d][i] = mem[bank][exp_addr(d, i)];
            issued[d] = 0; acc[d] = 0; dones[d] = 0; last_prev[d] = 0;
        end

        clr = 1'b0; fft_done = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        fft_done = 1'b1; bank_select = bank; out_ready = ready_at(mode, 0);
        cyc = 0; abort_cyc = -1; first_beat = -1; last_beat = -1;
        finished = 0; redge = 0;

        while (!finished && cyc < LIMIT) begin
            @(negedge clk);
            if (abort_cyc >= 0 && cyc > abort_cyc) begin
                check_idle("post_clr");
                if (cyc >= abort_cyc + 5) finished = 1;
            end else if (abort_cyc < 0 || cyc != abort_cyc) begin
                for (int d = 0; d < 2; d++) begin
                    automatic bit busy_exp = (cyc >= 1) && !(last_beat >= 0 && cyc > last_beat);
                    chk("busy", busy[d], 32'(busy_exp));
                    if (busy_exp) chk("rd_bank", rd_bank[d], bank);
                    if (cyc == 0) begin
                        chk("start_rd_en", rd_en[d], 0);
                        chk("start_out_valid", out_valid[d], 0);
                    end
                    if (cyc == 1) begin
                        chk("first_rd_en", rd_en[d], 1);
                        chk("first_out_valid_early", out_valid[d], 0);
                    end
                    if (cyc == 2) chk("first_out_valid", out_valid[d], 1);
                    if (mode == 3 && cyc == 6) chk("stall_reads_le2", 32'(issued[d] <= 2), 1);
                    if (rd_en[d]) begin
                        chk("rd_en_bound", 32'(issued[d] < N), 1);
                        chk("rd_window", 32'((issued[d] - acc[d]) < 2), 1);
                        chk("rd_address", rd_address[d], exp_addr(d, issued[d] % N));
                        issued[d]++;
                    end
                    chk("readout_done", readout_done[d], 32'(last_prev[d]));
                    if (readout_done[d]) dones[d]++;
                    last_prev[d] = 0;
                    if (acc[d] >= N) begin
                        chk("no_extra_beat", out_valid[d], 0);
                    end else if (out_valid[d]) begin
                        chk("out_index", out_index[d], acc[d]);
                        chk("out_data", out_data[d], expd[d][acc[d]]);
                        chk("out_last", out_last[d], 32'(acc[d] == N - 1));
                        if (out_ready) begin
                            if (d == 0 && first_beat < 0) first_beat = cyc;
                            if (d == 0 && acc[d] == clr_beat) abort_cyc = cyc + 1;
                            if (d == 0 && acc[d] == redge_beat) redge = 1;
                            acc[d]++;
                            if (acc[d] == N) begin
                                last_prev[d] = 1;
                                if (d == 0) last_beat = cyc;
                            end
                        end
                    end
                end
                if (last_beat >= 0 && cyc >= last_beat + 4) finished = 1;
            end
            @(posedge clk);
            #1;
            cyc++;
            fft_done    = (cyc < 3) || redge;
            bank_select = (cyc >= 2) ? ~bank : bank;
            out_ready   = ready_at(mode, cyc);
            clr         = (abort_cyc >= 0 && cyc == abort_cyc);
        end

        chk("readout_terminated", 32'(finished), 1);
        if (abort_cyc < 0) begin
            for (int d = 0; d < 2; d++) begin
                chk("beat_count", acc[d], N);
                chk("done_pulses", dones[d], 1);
            end
            if (mode == 0) begin
                chk("first_beat_cycle", first_beat, 2);
                chk("beat_span", last_beat - first_beat, N - 1);
            end
        end
        clr = 1'b0;
    endtask

    initial begin
        clr = 1'b1; fft_done = 1'b0; bank_select = 1'b1; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_rd_en", rd_en[d], 0);
            chk("rst_rd_address", rd_address[d], 0);
            chk("rst_rd_bank", rd_bank[d], 0);
            chk("rst_out_valid", out_valid[d], 0);
            chk("rst_out_data", out_data[d], 0);
            chk("rst_out_index", out_index[d], 0);
            chk("rst_out_last", out_last[d], 0);
            chk("rst_busy", busy[d], 0);
            chk("rst_readout_done", readout_done[d], 0);
        end
        @(posedge clk); #1; clr = 1'b0;

        // identity memory, full-rate stream (bin 1 of the bit-reversed unit carries 16)
        run_readout(0, -1, -1, 1'b0, 1'b0);
        // 1,0,0,1 ready pattern
        run_readout(1, -1, -1, 1'b0, 1'b1);
        // bank 1 selected, bank_select flips two cycles later
        run_readout(0, -1, -1, 1'b1, 1'b1);
        // second fft_done edge at beat 10
        run_readout(0, -1, 10, 1'b0, 1'b1);
        // reset at beat 15, then a clean readout
        run_readout(2, 15, -1, 1'b1, 1'b1);
        run_readout(0, -1, -1, 1'b0, 1'b0);

        // fft_done already high when reset is released: no start
        @(posedge clk); #1;
        fft_done = 1'b1; clr = 1'b1;
        repeat (2) @(posedge clk);
        #1; clr = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_idle("held_done");
        end

        // output stalled for 5 cycles after start
        run_readout(3, -1, -1, 1'b1, 1'b1);
        for (int r = 0; r < 3; r++) run_readout(2, -1, -1, 1'($urandom_range(0, 1)), 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_readout_unit.md
FFT_READOUT_UNIT -- requirements
Module: fft_readout_unit

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high, ports named clk and clr.
REQ-002 Parameter DATA_W, default 16, SHALL set the width of each real/imaginary sample word.
REQ-003 Parameter ADDR_W, default 5, SHALL set the memory address width; point count N = 2^ADDR_W.
REQ-004 Parameter BITREV, default 1, SHALL select bit-reversed read addressing (1) or natural addressing (0).
REQ-005 Ports, in order:
 - clk  in  1  system clock
 - clr  in  1  synchronous active-high reset
 - fft_done  in  1  level from the FFT address generator; a rising edge starts readout
 - bank_select  in  1  bank holding final results; sampled on the start edge
 - rd_en  out  1  memory read strobe; data returns exactly 1 cycle later
 - rd_address  out  ADDR_W  memory read address
 - rd_bank  out  1  bank to read, held constant for the whole readout
 - rd_data  in  2*DATA_W  {re, im}, valid the cycle after rd_en
 - out_valid  out  1  output beat valid
 - out_ready  in  1  downstream accept
 - out_data  out  2*DATA_W  {re, im} of bin out_index
 - out_index  out  ADDR_W  bin number, natural order 0..N-1
 - out_last  out  1  high on the beat with out_index = N-1
 - busy  out  1  readout in progress
 - readout_done  out  1  one-cycle pulse after the last beat is accepted

Function
REQ-006 The block SHALL implement states IDLE, RUN and FLUSH.
REQ-007 IDLE SHALL transition to RUN on the cycle fft_done is 1 and its registered copy is 0; bank_select SHALL be latched into rd_bank on that same edge.
REQ-008 In RUN the read counter k SHALL run 0..N-1; rd_address SHALL be bitrev(k) when BITREV=1 and k otherwise.
REQ-009 rd_en SHALL assert only when (buffer occupancy + reads in flight) < 2, so no returned word is ever lost.
REQ-010 Returned rd_data SHALL enter a 2-entry FIFO; out_valid SHALL be high whenever the FIFO is non-empty; a beat transfers when out_valid and out_ready are both 1.
REQ-011 out_data, out_index and out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-012 After the read with k = N-1 is issued, the state SHALL go to FLUSH; FLUSH SHALL return to IDLE in the cycle the out_last beat transfers, and readout_done SHALL pulse in the next cycle.
REQ-013 Latency: with out_ready held 1, the first rd_en SHALL be 1 cycle after the start edge and the first out_valid 2 cycles after it.
REQ-014 Throughput: with out_ready held 1, the N beats SHALL transfer on N consecutive cycles.
REQ-015 fft_done edges arriving while busy=1 SHALL be ignored, and a new readout SHALL NOT be queued.
REQ-016 busy SHALL be 1 in RUN and FLUSH and 0 in IDLE.
REQ-017 The counter SHALL NOT wrap past N-1; once k = N-1 has been issued, no further rd_en SHALL occur in that readout.
REQ-018 The FIFO SHALL support a simultaneous push and pop when full; occupancy then stays 2.

Reset
REQ-019 While clr=1 the block SHALL go to IDLE, empty the FIFO, clear k and the in-flight flag, and clear the fft_done edge register.
REQ-020 After reset all outputs SHALL be 0: rd_en, rd_address, rd_bank, out_valid, out_data, out_index, out_last, busy and readout_done.
REQ-021 clr asserted mid-readout SHALL abort it; no further rd_en or out_valid occurs, and the in-flight read data returning in the following cycle SHALL be discarded.
REQ-022 If fft_done is already 1 when clr is released, readout SHALL NOT start; the edge register reloads to 1 on the first cycle after reset, so a fresh rising edge is required.

Structure
REQ-023 ADDR_W default, DATA_W default and a bit-reverse function SHALL reside in a shared package fft_pkg, for reuse by the address generator and loader.
REQ-024 The 2-entry FIFO SHALL be a sub-module named skid_fifo_2, parameterised by width; all other logic stays in fft_readout_unit.

Verification
REQ-025 Memory model holding value k at address k, BITREV=1, out_ready=1, pulse fft_done -> 32 beats on consecutive cycles, out_index 0..31, out_data = bitrev5(out_index) (index 1 carries data 16), out_last only on index 31, readout_done 1 cycle later.
REQ-026 Same setup with out_ready toggling 1,0,0,1 repeatedly -> no lost or duplicated beats, every out_index 0..31 appears exactly once in order, and out_data is stable during every stall.
REQ-027 bank_select=1 at the start edge, then bank_select=0 two cycles later -> rd_bank stays 1 for the whole readout.
REQ-028 Second fft_done rising edge at beat 10 -> ignored; exactly 32 beats, one readout_done.
REQ-029 clr asserted at beat 15 -> on the next cycle out_valid=0, busy=0 and rd_en=0; a later fft_done edge starts a clean readout from index 0.
REQ-030 BITREV=0, out_ready=0 for 5 cycles after start -> at most 2 rd_en issued; then out_ready=1 -> out_data = out_index for all 32 beats.
